// File: rtl/ucie_ctl_sb_serializer_pkg.sv
// Shared constants and helpers for the sideband transmit serializer.
package ucie_ctl_sb_serializer_pkg;

    localparam int WORD_W = 32;

    typedef logic [0:0] sb_state_t;
    localparam sb_state_t ST_IDLE  = 1'b0;
    localparam sb_state_t ST_SHIFT = 1'b1;

    function automatic int sb_beats(input int n);
        return WORD_W / n;
    endfunction

    // Counter is never narrower than one bit, even when a word is a single beat.
    function automatic int sb_cnt_w(input int n);
        int b;
        b = WORD_W / n;
        return (b <= 1) ? 1 : $clog2(b);
    endfunction

endpackage

// File: rtl/ucie_ctl_sb_serializer_if.sv
// Word-in / chunk-out bundle of the sideband serializer.
// Both handshakes: a transfer happens on a clock edge where valid and ready are both high;
// the source holds data stable while valid is high and ready is low.
interface ucie_ctl_sb_serializer_if #(
    parameter int N = 8
);
    logic          i_flush;
    logic [31:0]   i_word;
    logic          i_word_valid;
    logic          o_word_ready;
    logic [N-1:0]  o_data_out;
    logic          o_data_valid;
    logic          i_out_ready;
    logic          o_last;
    logic          o_busy;
    logic          o_state;

    modport slave (
        input  i_flush, i_word, i_word_valid, i_out_ready,
        output o_word_ready, o_data_out, o_data_valid, o_last, o_busy, o_state
    );

    modport master (
        output i_flush, i_word, i_word_valid, i_out_ready,
        input  o_word_ready, o_data_out, o_data_valid, o_last, o_busy, o_state
    );

endinterface

// File: rtl/ucie_ctl_sb_serializer.sv
// Sideband transmit serializer: one 32-bit word in, 32/N chunks of N bits out, MSB chunk first.
// o_state mirrors the FSM register for debug visibility.
module ucie_ctl_sb_serializer
    import ucie_ctl_sb_serializer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    ucie_ctl_sb_serializer_if.slave   sb
);

    localparam int BEATS = sb_beats(N);
    localparam int CW    = sb_cnt_w(N);

    if ((WORD_W % N) != 0) begin : g_bad_n
        $error("ucie_ctl_sb_serializer: N must divide 32");
    end

    sb_state_t      state_q, state_d;
    logic [31:0]    shreg_q, shreg_d;
    logic [CW-1:0]  cnt_q,   cnt_d;

    logic is_shift;
    logic last;
    logic beat_acc;
    logic word_ready;
    logic load;

    assign is_shift = (state_q == ST_SHIFT);
    assign last     = is_shift && (cnt_q == '0);
    assign beat_acc = is_shift && sb.i_out_ready;

    // Ready never depends on i_word_valid, so no loop through the packet builder.
    assign word_ready = i_reset && !sb.i_flush && (!is_shift || (last && sb.i_out_ready));
    assign load       = word_ready && sb.i_word_valid;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (sb.i_flush) begin
            state_d = ST_IDLE;
            shreg_d = '0;
            cnt_d   = '0;
        end else if (load) begin
            state_d = ST_SHIFT;
            shreg_d = sb.i_word;
            cnt_d   = CW'(BEATS - 1);
        end else if (beat_acc) begin
            shreg_d = shreg_q << N;
            if (last) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sb.o_word_ready = word_ready;
    assign sb.o_data_valid = is_shift;
    assign sb.o_data_out   = is_shift ? shreg_q[31 -: N] : '0;
    assign sb.o_last       = last;
    assign sb.o_busy       = is_shift;
    assign sb.o_state      = state_q;

endmodule

// File: tb/tb_ucie_ctl_sb_serializer.sv
// Directed checks of the sideband serializer plus loopback into a receive shift register.
module tb_ucie_ctl_sb_serializer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic lb_go;
    logic [3:0] lb_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    ucie_ctl_sb_serializer_if #(.N(8)) m_if();
    ucie_ctl_sb_serializer_if #(.N(4)) f_if();

    ucie_ctl_sb_serializer #(.N(8)) u_dut_m (.i_clk(clk), .i_reset(rst_n), .sb(m_if));
    ucie_ctl_sb_serializer #(.N(4)) u_dut_f (.i_clk(clk), .i_reset(rst_n), .sb(f_if));

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic look_m(input string tag, input logic busy, input logic valid,
                          input logic last, input logic wr, input logic [7:0] data);
        #1;
        check_eq(tag, {20'd0, m_if.o_busy, m_if.o_data_valid, m_if.o_last, m_if.o_word_ready, m_if.o_data_out},
                      {20'd0, busy, valid, last, wr, data});
    endtask

    task automatic look_f(input string tag, input logic busy, input logic valid,
                          input logic last, input logic wr, input logic [3:0] data);
        #1;
        check_eq(tag, {24'd0, f_if.o_busy, f_if.o_data_valid, f_if.o_last, f_if.o_word_ready, f_if.o_data_out},
                      {24'd0, busy, valid, last, wr, data});
    endtask

    // Loopback: each width drives its own DUT into an LSB-shifting receive register.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lb
        localparam int LN = (gi == 0) ? 1 : (gi == 1) ? 8 : (gi == 2) ? 16 : 32;
        localparam int WORDS = 40;

        ucie_ctl_sb_serializer_if #(.N(LN)) lb_if();
        ucie_ctl_sb_serializer #(.N(LN)) u_dut_lb (.i_clk(clk), .i_reset(rst_n), .sb(lb_if));

        logic [31:0] rx_q;
        always_ff @(posedge clk) begin
            if (lb_if.o_data_valid && lb_if.i_out_ready) begin
                rx_q <= (rx_q << LN) | 32'(lb_if.o_data_out);
            end
        end

        initial begin
            logic [31:0] exp_q[$];
            int   sent;
            int   got;
            logic acc_word;
            logic fin;
            sent = 0;
            got  = 0;
            lb_if.i_flush      = 1'b0;
            lb_if.i_word       = '0;
            lb_if.i_word_valid = 1'b0;
            lb_if.i_out_ready  = 1'b0;
            wait (lb_go);
            for (int c = 0; c < 8000 && got < WORDS; c++) begin
                @(negedge clk);
                if (!lb_if.i_word_valid && sent < WORDS && $urandom_range(0, 3) != 0) begin
                    lb_if.i_word       = $urandom;
                    lb_if.i_word_valid = 1'b1;
                end
                lb_if.i_out_ready = ($urandom_range(0, 3) != 0);
                #1;
                acc_word = lb_if.i_word_valid && lb_if.o_word_ready;
                fin      = lb_if.o_data_valid && lb_if.i_out_ready && lb_if.o_last;
                @(posedge clk);
                #1;
                if (acc_word) begin
                    exp_q.push_back(lb_if.i_word);
                    sent++;
                    lb_if.i_word_valid = 1'b0;
                end
                if (fin) begin
                    check_eq($sformatf("lb_word_n%0d", LN), rx_q, exp_q.pop_front());
                    got++;
                end
            end
            check_eq($sformatf("lb_count_n%0d", LN), got, WORDS);
            lb_if.i_out_ready = 1'b0;
            lb_done[gi] = 1'b1;
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        lb_go = 1'b0;
        lb_done = '0;
        rst_n = 1'b0;
        m_if.i_flush = 1'b0; m_if.i_word = '0; m_if.i_word_valid = 1'b0; m_if.i_out_ready = 1'b0;
        f_if.i_flush = 1'b0; f_if.i_word = '0; f_if.i_word_valid = 1'b0; f_if.i_out_ready = 1'b0;

        #1;
        look_m("rst_m", 0, 0, 0, 0, 8'h00);
        look_f("rst_f", 0, 0, 0, 0, 4'h0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        look_m("rst_rel", 0, 0, 0, 1, 8'h00);

        // Single word, no stalls.
        step; m_if.i_word = 32'hDEADBEEF; m_if.i_word_valid = 1'b1; m_if.i_out_ready = 1'b1;
        look_m("t1_idle", 0, 0, 0, 1, 8'h00);
        step; m_if.i_word_valid = 1'b0;
        look_m("t1_b0", 1, 1, 0, 0, 8'hDE);
        step; look_m("t1_b1", 1, 1, 0, 0, 8'hAD);
        step; look_m("t1_b2", 1, 1, 0, 0, 8'hBE);
        step; look_m("t1_b3", 1, 1, 1, 1, 8'hEF);
        step; look_m("t1_end", 0, 0, 0, 1, 8'h00);

        // Three-cycle stall on beat 2.
        step; m_if.i_word = 32'hDEADBEEF; m_if.i_word_valid = 1'b1; m_if.i_out_ready = 1'b1;
        step; m_if.i_word_valid = 1'b0;
        look_m("t2_b0", 1, 1, 0, 0, 8'hDE);
        step; m_if.i_out_ready = 1'b0;
        look_m("t2_stall0", 1, 1, 0, 0, 8'hAD);
        step; look_m("t2_stall1", 1, 1, 0, 0, 8'hAD);
        step; look_m("t2_stall2", 1, 1, 0, 0, 8'hAD);
        step; m_if.i_out_ready = 1'b1;
        look_m("t2_go", 1, 1, 0, 0, 8'hAD);
        step; look_m("t2_b2", 1, 1, 0, 0, 8'hBE);
        step; look_m("t2_b3", 1, 1, 1, 1, 8'hEF);
        step; look_m("t2_end", 0, 0, 0, 1, 8'h00);

        // Back-to-back words, no bubble.
        step; m_if.i_word = 32'h01234567; m_if.i_word_valid = 1'b1; m_if.i_out_ready = 1'b1;
        step; m_if.i_word = 32'h89ABCDEF;
        look_m("t3_w0b0", 1, 1, 0, 0, 8'h01);
        step; look_m("t3_w0b1", 1, 1, 0, 0, 8'h23);
        step; look_m("t3_w0b2", 1, 1, 0, 0, 8'h45);
        step; look_m("t3_w0b3", 1, 1, 1, 1, 8'h67);
        step; m_if.i_word_valid = 1'b0;
        look_m("t3_w1b0", 1, 1, 0, 0, 8'h89);
        step; look_m("t3_w1b1", 1, 1, 0, 0, 8'hAB);
        step; look_m("t3_w1b2", 1, 1, 0, 0, 8'hCD);
        step; look_m("t3_w1b3", 1, 1, 1, 1, 8'hEF);
        step; look_m("t3_end", 0, 0, 0, 1, 8'h00);

        // Flush during beat 4 of a nibble-wide word; the word offered then must wait.
        step; f_if.i_word = 32'hCAFEF00D; f_if.i_word_valid = 1'b1; f_if.i_out_ready = 1'b1;
        step; f_if.i_word_valid = 1'b0;
        look_f("t4_b0", 1, 1, 0, 0, 4'hC);
        step; look_f("t4_b1", 1, 1, 0, 0, 4'hA);
        step; look_f("t4_b2", 1, 1, 0, 0, 4'hF);
        step; f_if.i_flush = 1'b1; f_if.i_word = 32'h12345678; f_if.i_word_valid = 1'b1;
        look_f("t4_flush", 1, 1, 0, 0, 4'hE);
        step; f_if.i_flush = 1'b0;
        look_f("t4_after", 0, 0, 0, 1, 4'h0);
        step; f_if.i_word_valid = 1'b0;
        look_f("t4_n1", 1, 1, 0, 0, 4'h1);
        for (int i = 2; i <= 8; i++) begin
            step;
            look_f($sformatf("t4_n%0d", i), 1, 1, (i == 8), (i == 8), 4'(i));
        end
        step; look_f("t4_end", 0, 0, 0, 1, 4'h0);

        // Asynchronous reset in the middle of a word.
        step; m_if.i_word = 32'hDEADBEEF; m_if.i_word_valid = 1'b1; m_if.i_out_ready = 1'b1;
        step; m_if.i_word_valid = 1'b0;
        look_m("t5_b0", 1, 1, 0, 0, 8'hDE);
        step; look_m("t5_b1", 1, 1, 0, 0, 8'hAD);
        rst_n = 1'b0;
        look_m("t5_rst", 0, 0, 0, 0, 8'h00);
        #2;
        rst_n = 1'b1;
        look_m("t5_rel", 0, 0, 0, 1, 8'h00);
        step; look_m("t5_idle0", 0, 0, 0, 1, 8'h00);
        step; look_m("t5_idle1", 0, 0, 0, 1, 8'h00);

        lb_go = 1'b1;
        for (int c = 0; c < 40000 && lb_done != 4'hF; c++) begin
            @(posedge clk);
        end
        check_eq("lb_all_done", {28'd0, lb_done}, 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
